// File: rtl/frame_buffer_port_arbiter_if.sv
// Purpose: bundles the requester handshakes and the single-port memory command/return bus.
// Latency: none, wiring only.
// Backpressure: requests are held until the matching gnt; memory side has no backpressure.
// Ports (slave = arbiter view):
//   wr_req_i/wr_addr_i/wr_data_i -> wr_gnt_o      camera-side write requester
//   rd_req_i/rd_addr_i -> rd_gnt_o, rd_data_o/rd_valid_o   HDMI-side read requester
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o -> memory, mem_rdata_i <- memory
interface frame_buffer_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);
    logic                  wr_req_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  wr_gnt_o;
    logic                  rd_req_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  rd_gnt_o;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, mem_rdata_i,
        output wr_gnt_o, rd_gnt_o, rd_data_o, rd_valid_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, mem_rdata_i,
        input  wr_gnt_o, rd_gnt_o, rd_data_o, rd_valid_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/frame_buffer_port_arbiter.sv
// Purpose: round-robin, bounded-burst arbiter sharing one single-port frame buffer between writer and reader.
// Latency: grant is combinational; memory command 1 cycle after grant; rd_valid_o 1+RD_LATENCY cycles after rd grant.
// Backpressure: requesters hold req/addr/data until granted; a side waiting on the other gets the port within BURST_LEN grants.
// Ports: clk_i, resetn_i (async active-low), bus (frame_buffer_port_arbiter_if.slave).
// Memory timing: mem_rdata_i is sampled at the end of the RD_LATENCY-th cycle counting the mem_en_o cycle as the first.
module frame_buffer_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                          clk_i,
    input  logic                          resetn_i,
    frame_buffer_port_arbiter_if.slave    bus
);
    localparam int               CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic                  last_wr_q, last_wr_d;     // 1 = write side served last
    logic                  wr_gnt, rd_gnt;

    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [RD_LATENCY-1:0] rd_vld_pipe_q, rd_vld_pipe_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    assign wr_gnt = (state_q == ST_WRITE) && bus.wr_req_i;
    assign rd_gnt = (state_q == ST_READ)  && bus.rd_req_i;

    // Shift in one bit per issued read; the top bit is the read return strobe.
    assign rd_vld_pipe_d = RD_LATENCY'({rd_vld_pipe_q, (mem_en_q && !mem_we_q)});

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        last_wr_d   = last_wr_q;
        case (state_q)
            ST_IDLE: begin
                // Ties go to whichever side was not served last.
                if (bus.wr_req_i && (!bus.rd_req_i || !last_wr_q)) begin
                    state_d = ST_WRITE;
                end else if (bus.rd_req_i) begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (bus.wr_req_i) begin
                    if (burst_cnt_q == CNT_LAST) begin
                        // Burst exhausted: hand over if the reader waits, else restart the burst.
                        burst_cnt_d = '0;
                        if (bus.rd_req_i) begin
                            state_d   = ST_READ;
                            last_wr_d = 1'b1;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else begin
                    burst_cnt_d = '0;
                    last_wr_d   = 1'b1;
                    state_d     = bus.rd_req_i ? ST_READ : ST_IDLE;
                end
            end
            ST_READ: begin
                if (bus.rd_req_i) begin
                    if (burst_cnt_q == CNT_LAST) begin
                        burst_cnt_d = '0;
                        if (bus.wr_req_i) begin
                            state_d   = ST_WRITE;
                            last_wr_d = 1'b0;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else begin
                    burst_cnt_d = '0;
                    last_wr_d   = 1'b0;
                    state_d     = bus.wr_req_i ? ST_WRITE : ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q       <= ST_IDLE;
            burst_cnt_q   <= '0;
            last_wr_q     <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd_vld_pipe_q <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            last_wr_q     <= last_wr_d;
            mem_en_q      <= wr_gnt || rd_gnt;
            mem_we_q      <= wr_gnt;
            // Address/data hold their last value on idle cycles; reads leave wdata untouched.
            if (wr_gnt) begin
                mem_addr_q  <= bus.wr_addr_i;
                mem_wdata_q <= bus.wr_data_i;
            end else if (rd_gnt) begin
                mem_addr_q  <= bus.rd_addr_i;
            end
            rd_vld_pipe_q <= rd_vld_pipe_d;
            // Capture the data on the same edge its valid reaches the output stage.
            if (rd_vld_pipe_d[RD_LATENCY-1]) begin
                rd_data_q <= bus.mem_rdata_i;
            end
        end
    end

    assign bus.wr_gnt_o    = wr_gnt;
    assign bus.rd_gnt_o    = rd_gnt;
    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.rd_valid_o  = rd_vld_pipe_q[RD_LATENCY-1];
    assign bus.rd_data_o   = rd_data_q;
endmodule

// File: tb/tb_frame_buffer_port_arbiter.sv
// Purpose: drives two arbiter instances (BURST_LEN 16/RD_LATENCY 2 and BURST_LEN 1/RD_LATENCY 1) with random requests.
// Latency: inputs change 1 time unit after posedge; outputs are compared at negedge against a reference model.
// Backpressure: requesters hold address/data until they see their grant, occasionally dropping a request.
module tb_frame_buffer_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int BL0 = 16;
    localparam int RL0 = 2;
    localparam int BL1 = 1;
    localparam int RL1 = 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    frame_buffer_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    frame_buffer_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    frame_buffer_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL0), .RD_LATENCY(RL0))
        u_dut0 (.clk_i(clk), .resetn_i(resetn), .bus(bus0));
    frame_buffer_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL1), .RD_LATENCY(RL1))
        u_dut1 (.clk_i(clk), .resetn_i(resetn), .bus(bus1));

    // Requester and memory-side drive, one element per instance.
    logic          wr_req [2];
    logic [AW-1:0] wr_addr [2];
    logic [DW-1:0] wr_data [2];
    logic          rd_req [2];
    logic [AW-1:0] rd_addr [2];
    logic [DW-1:0] mem_rdata [2];

    assign bus0.wr_req_i = wr_req[0];    assign bus1.wr_req_i = wr_req[1];
    assign bus0.wr_addr_i = wr_addr[0];  assign bus1.wr_addr_i = wr_addr[1];
    assign bus0.wr_data_i = wr_data[0];  assign bus1.wr_data_i = wr_data[1];
    assign bus0.rd_req_i = rd_req[0];    assign bus1.rd_req_i = rd_req[1];
    assign bus0.rd_addr_i = rd_addr[0];  assign bus1.rd_addr_i = rd_addr[1];
    assign bus0.mem_rdata_i = mem_rdata[0]; assign bus1.mem_rdata_i = mem_rdata[1];

    logic          o_wg [2], o_rg [2], o_en [2], o_we [2], o_rv [2];
    logic [AW-1:0] o_addr [2];
    logic [DW-1:0] o_wd [2], o_rd [2];
    assign o_wg[0] = bus0.wr_gnt_o;      assign o_wg[1] = bus1.wr_gnt_o;
    assign o_rg[0] = bus0.rd_gnt_o;      assign o_rg[1] = bus1.rd_gnt_o;
    assign o_en[0] = bus0.mem_en_o;      assign o_en[1] = bus1.mem_en_o;
    assign o_we[0] = bus0.mem_we_o;      assign o_we[1] = bus1.mem_we_o;
    assign o_addr[0] = bus0.mem_addr_o;  assign o_addr[1] = bus1.mem_addr_o;
    assign o_wd[0] = bus0.mem_wdata_o;   assign o_wd[1] = bus1.mem_wdata_o;
    assign o_rv[0] = bus0.rd_valid_o;    assign o_rv[1] = bus1.rd_valid_o;
    assign o_rd[0] = bus0.rd_data_o;     assign o_rd[1] = bus1.rd_data_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state: who owns the port (0 none, 1 writer, 2 reader), grants in current run.
    int            m_serv [2];
    int            m_run [2];
    bit            m_lastw [2];
    bit            pe_en [2], pe_we [2];
    logic [AW-1:0] pe_addr [2];
    logic [DW-1:0] pe_wd [2];
    bit            exp_v [2][64];
    logic [DW-1:0] exp_d [2][64];
    logic [DW-1:0] refmem [longint];
    logic [DW-1:0] emumem [longint];
    logic [DW-1:0] hist [2][4];
    bit            last_wg [2], last_rg [2];
    int            wa [2], ra [2];

    function automatic longint mkey(input int k, input logic [AW-1:0] a);
        return (longint'(k) << 32) | longint'({32'b0, a});
    endfunction

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return (a[15:0] * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic int bl_of(input int k);
        return (k == 0) ? BL0 : BL1;
    endfunction

    function automatic int rl_of(input int k);
        return (k == 0) ? RL0 : RL1;
    endfunction

    task automatic drive(input int k, input bit rst, input int pw, input int pr, input int pd);
        if (!rst) begin
            if (wr_req[k] && last_wg[k]) wr_req[k] = 1'b0;
            if (rd_req[k] && last_rg[k]) rd_req[k] = 1'b0;
            if (wr_req[k] && $urandom_range(99) < pd) wr_req[k] = 1'b0;
            if (rd_req[k] && $urandom_range(99) < pd) rd_req[k] = 1'b0;
        end
        if (!wr_req[k] && (rst || $urandom_range(99) < pw)) begin
            wr_req[k]  = 1'b1;
            wr_addr[k] = AW'(wa[k]);
            wr_data[k] = DW'($urandom);
            wa[k]      = (wa[k] + 1) % 128;
        end
        if (!rd_req[k] && (rst || $urandom_range(99) < pr)) begin
            rd_req[k]  = 1'b1;
            rd_addr[k] = AW'(ra[k]);
            ra[k]      = ($urandom_range(9) == 0) ? int'($urandom_range(127)) : (ra[k] + 1) % 128;
        end
    endtask

    task automatic eval(input int k);
        bit ewg, erg, mine, other;
        int slot;
        string u;
        u = $sformatf("u%0d.", k);
        if (!resetn) begin
            m_serv[k] = 0; m_run[k] = 0; m_lastw[k] = 1'b0; pe_en[k] = 1'b0;
            for (int i = 0; i < 64; i++) exp_v[k][i] = 1'b0;
        end
        ewg = resetn && (m_serv[k] == 1) && wr_req[k];
        erg = resetn && (m_serv[k] == 2) && rd_req[k];
        chk({u, "wr_gnt"}, 64'(o_wg[k]), 64'(ewg));
        chk({u, "rd_gnt"}, 64'(o_rg[k]), 64'(erg));
        chk({u, "mem_en"}, 64'(o_en[k]), 64'(pe_en[k]));
        if (pe_en[k]) begin
            chk({u, "mem_we"}, 64'(o_we[k]), 64'(pe_we[k]));
            chk({u, "mem_addr"}, 64'(o_addr[k]), 64'(pe_addr[k]));
            if (pe_we[k]) chk({u, "mem_wdata"}, 64'(o_wd[k]), 64'(pe_wd[k]));
        end
        if (!resetn) begin
            chk({u, "rst_we"}, 64'(o_we[k]), 64'(0));
            chk({u, "rst_addr"}, 64'(o_addr[k]), 64'(0));
            chk({u, "rst_wdata"}, 64'(o_wd[k]), 64'(0));
            chk({u, "rst_rdata"}, 64'(o_rd[k]), 64'(0));
        end
        slot = cyc % 64;
        chk({u, "rd_valid"}, 64'(o_rv[k]), 64'(exp_v[k][slot]));
        if (exp_v[k][slot]) chk({u, "rd_data"}, 64'(o_rd[k]), 64'(exp_d[k][slot]));
        exp_v[k][slot] = 1'b0;
        last_wg[k] = o_wg[k];
        last_rg[k] = o_rg[k];

        if (resetn) begin
            // Memory command expected one cycle after the grant.
            pe_en[k] = ewg || erg;
            pe_we[k] = ewg;
            pe_addr[k] = ewg ? wr_addr[k] : rd_addr[k];
            if (ewg) begin
                pe_wd[k] = wr_data[k];
                refmem[mkey(k, wr_addr[k])] = wr_data[k];
            end
            if (erg) begin
                slot = (cyc + 1 + rl_of(k)) % 64;
                exp_v[k][slot] = 1'b1;
                exp_d[k][slot] = refmem.exists(mkey(k, rd_addr[k])) ? refmem[mkey(k, rd_addr[k])]
                                                                     : dflt(rd_addr[k]);
            end
            // Arbitration rules: fair tie-break from idle, hand over after BURST_LEN grants or when owner stops.
            if (m_serv[k] == 0) begin
                if (wr_req[k] && (!rd_req[k] || !m_lastw[k])) m_serv[k] = 1;
                else if (rd_req[k]) m_serv[k] = 2;
            end else begin
                mine  = (m_serv[k] == 1) ? wr_req[k] : rd_req[k];
                other = (m_serv[k] == 1) ? rd_req[k] : wr_req[k];
                if (mine) begin
                    m_run[k]++;
                    if (m_run[k] == bl_of(k)) begin
                        m_run[k] = 0;
                        if (other) begin
                            m_lastw[k] = (m_serv[k] == 1);
                            m_serv[k]  = 3 - m_serv[k];
                        end
                    end
                end else begin
                    m_lastw[k] = (m_serv[k] == 1);
                    m_run[k]   = 0;
                    m_serv[k]  = other ? 3 - m_serv[k] : 0;
                end
            end
        end

        // Memory emulation from the DUT's actual command; data shows up RD_LATENCY-1 cycles later.
        for (int i = 3; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = DW'($urandom);
        if (o_en[k] && o_we[k]) emumem[mkey(k, o_addr[k])] = o_wd[k];
        if (o_en[k] && !o_we[k])
            hist[k][0] = emumem.exists(mkey(k, o_addr[k])) ? emumem[mkey(k, o_addr[k])] : dflt(o_addr[k]);
        mem_rdata[k] = hist[k][rl_of(k) - 1];
    endtask

    task automatic run(input int n, input bit rst, input int pw, input int pr, input int pd);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            resetn = !rst;
            for (int k = 0; k < 2; k++) drive(k, rst, pw, pr, pd);
            @(negedge clk);
            for (int k = 0; k < 2; k++) eval(k);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            wr_req[k] = 1'b0; rd_req[k] = 1'b0;
            wr_addr[k] = '0; rd_addr[k] = '0; wr_data[k] = '0; mem_rdata[k] = '0;
            m_serv[k] = 0; m_run[k] = 0; m_lastw[k] = 1'b0;
            pe_en[k] = 1'b0; pe_we[k] = 1'b0; pe_addr[k] = '0; pe_wd[k] = '0;
            last_wg[k] = 1'b0; last_rg[k] = 1'b0;
            wa[k] = 0; ra[k] = 100;
            for (int i = 0; i < 64; i++) begin exp_v[k][i] = 1'b0; exp_d[k][i] = '0; end
            for (int i = 0; i < 4; i++) hist[k][i] = '0;
        end
        run(5, 1'b1, 100, 100, 0);   // reset with both requesting
        run(80, 1'b0, 100, 100, 0);  // both saturated: bursts and handover
        run(20, 1'b0, 0, 0, 100);    // drain everything
        run(40, 1'b0, 100, 0, 0);    // write stream
        run(5, 1'b0, 0, 0, 100);
        run(12, 1'b0, 0, 100, 0);    // read stream, reads left in flight
        run(3, 1'b1, 100, 100, 0);   // reset mid-operation
        run(30, 1'b0, 100, 100, 0);  // restart at write
        run(600, 1'b0, 60, 60, 5);   // random traffic with drops
        run(300, 1'b0, 20, 20, 10);  // sparse traffic, idle gaps
        run(10, 1'b0, 0, 0, 100);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
